// File: rtl/div_if.sv
// Operand/result bus of the iterative divider.
// Both channels use valid/ready: a transfer happens on a rising clock edge where
// valid and ready are both high; the source holds its payload while valid is high
// and ready is low. The sink's ready never depends combinationally on valid.
interface div_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] div_a;
  logic [WIDTH-1:0] div_b;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] div_r;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output div_a, div_b, in_valid, out_ready,
    input  in_ready, div_q, div_r, out_valid
  );

  modport slave (
    input  div_a, div_b, in_valid, out_ready,
    output in_ready, div_q, div_r, out_valid
  );
endinterface

// File: rtl/div.sv
// Iterative restoring divider: one quotient bit per clock, quotient/remainder
// held until the consumer takes them. One division in flight.
module div #(
  parameter int WIDTH  = 32,
  parameter bit SIGNED = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  div_if.slave       bus,
  output logic [1:0] o_dbg_state
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_FIXUP = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b_mag;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH:0]   r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_b_zero;

  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_acc_sh;
  logic [WIDTH:0]   w_acc_sub;
  logic             w_ge;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;

  assign w_a_mag = (SIGNED && bus.div_a[WIDTH-1]) ? -bus.div_a : bus.div_a;
  assign w_b_mag = (SIGNED && bus.div_b[WIDTH-1]) ? -bus.div_b : bus.div_b;

  // The dividend register doubles as the quotient: its MSB feeds the
  // accumulator while the new quotient bit enters at the LSB.
  assign w_acc_sh  = (r_acc << 1) | {{WIDTH{1'b0}}, r_dvd[WIDTH-1]};
  assign w_acc_sub = w_acc_sh - {1'b0, r_b_mag};
  assign w_ge      = (w_acc_sh >= {1'b0, r_b_mag});

  assign w_q_fix = r_neg_q ? -r_dvd : r_dvd;
  assign w_r_fix = r_neg_r ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_q         <= '0;
      r_r         <= '0;
      r_a         <= '0;
      r_b_mag     <= '0;
      r_dvd       <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_b_zero    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_in_ready && bus.in_valid) begin
            r_a        <= bus.div_a;
            r_dvd      <= w_a_mag;
            r_b_mag    <= w_b_mag;
            r_acc      <= '0;
            r_cnt      <= CW'(WIDTH - 1);
            r_neg_q    <= SIGNED & (bus.div_a[WIDTH-1] ^ bus.div_b[WIDTH-1]);
            r_neg_r    <= SIGNED & bus.div_a[WIDTH-1];
            r_b_zero   <= (bus.div_b == '0);
            r_in_ready <= 1'b0;
            r_state    <= S_CALC;
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        S_CALC: begin
          r_acc <= w_ge ? w_acc_sub : w_acc_sh;
          r_dvd <= {r_dvd[WIDTH-2:0], w_ge};
          if (r_cnt == '0) begin
            r_state <= S_FIXUP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_FIXUP: begin
          r_q     <= r_b_zero ? '1  : w_q_fix;
          r_r     <= r_b_zero ? r_a : w_r_fix;
          r_state <= S_DONE;
        end
        S_DONE: begin
          // First DONE cycle only raises out_valid, giving a WIDTH+2 latency.
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
          end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.div_q     = r_q;
  assign bus.div_r     = r_r;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_div.sv
// Bench for div: a signed and an unsigned instance share clock and reset;
// results are scoreboarded against a behavioural model.
module tb_div;
  localparam int W = 32;
  localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};
  localparam int LAT = W + 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic         tb_sel = 1'b0;
  logic [W-1:0] tb_a = '0;
  logic [W-1:0] tb_b = '0;
  logic         tb_valid = 1'b0;
  logic         tb_oready = 1'b0;
  logic [1:0]   dbg_s;
  logic [1:0]   dbg_u;

  div_if #(.WIDTH(W)) ifs ();
  div_if #(.WIDTH(W)) ifu ();

  assign ifs.div_a     = tb_a;
  assign ifs.div_b     = tb_b;
  assign ifs.in_valid  = tb_valid & tb_sel;
  assign ifs.out_ready = tb_oready & tb_sel;
  assign ifu.div_a     = tb_a;
  assign ifu.div_b     = tb_b;
  assign ifu.in_valid  = tb_valid & ~tb_sel;
  assign ifu.out_ready = tb_oready & ~tb_sel;

  div #(.WIDTH(W), .SIGNED(1'b1)) u_sdiv (.clk(clk), .rst(rst), .bus(ifs.slave), .o_dbg_state(dbg_s));
  div #(.WIDTH(W), .SIGNED(1'b0)) u_udiv (.clk(clk), .rst(rst), .bus(ifu.slave), .o_dbg_state(dbg_u));

  logic [W-1:0] obs_q, obs_r;
  logic         obs_ov, obs_ir;
  logic [1:0]   obs_st;
  assign obs_q  = tb_sel ? ifs.div_q     : ifu.div_q;
  assign obs_r  = tb_sel ? ifs.div_r     : ifu.div_r;
  assign obs_ov = tb_sel ? ifs.out_valid : ifu.out_valid;
  assign obs_ir = tb_sel ? ifs.in_ready  : ifu.in_ready;
  assign obs_st = tb_sel ? dbg_s         : dbg_u;

  logic [2*W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [2*W-1:0] model(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [W-1:0] sa, sb, sq, sr;
    if (b == '0) return {{W{1'b1}}, a};
    if (sgn) begin
      if (a == MIN && b == {W{1'b1}}) return {MIN, {W{1'b0}}};
      sa = a;
      sb = b;
      sq = sa / sb;
      sr = sa % sb;
      return {sq, sr};
    end
    return {a / b, a % b};
  endfunction

  task automatic start_op(input bit sel, input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    @(negedge clk);
    tb_sel = sel;
    #1;
    while (!obs_ir && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!obs_ir) begin
      errors++;
      $display("FAIL in_ready_timeout got 0 expected 1");
    end
    exp_q.push_back(model(sel, a, b));
    tb_a = a;
    tb_b = b;
    tb_valid = 1'b1;
    @(posedge clk);
    #1;
    tb_valid = 1'b0;
    tb_a = $urandom;
    tb_b = $urandom;
  endtask

  task automatic wait_result(output int edges);
    edges = 0;
    while (!obs_ov && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic collect(input int edges);
    logic [2*W-1:0] e;
    checks++;
    if (edges != LAT || !obs_ov) begin
      errors++;
      $display("FAIL latency got %0d expected %0d (out_valid=%0b)", edges, LAT, obs_ov);
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty got result %h/%h expected none", obs_q, obs_r);
      e = '0;
    end else begin
      e = exp_q.pop_front();
      if ({obs_q, obs_r} !== e) begin
        errors++;
        $display("FAIL result got q=%h r=%h expected q=%h r=%h (sel=%0b)",
                 obs_q, obs_r, e[2*W-1:W], e[W-1:0], tb_sel);
      end
    end
    @(negedge clk);
    tb_oready = 1'b1;
    @(posedge clk);
    #1;
    tb_oready = 1'b0;
    checks++;
    if (obs_ov !== 1'b0 || obs_ir !== 1'b1) begin
      errors++;
      $display("FAIL release got out_valid=%0b in_ready=%0b expected 0 1", obs_ov, obs_ir);
    end
  endtask

  task automatic do_op(input bit sel, input logic [W-1:0] a, input logic [W-1:0] b);
    int edges;
    start_op(sel, a, b);
    wait_result(edges);
    collect(edges);
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (ifs.in_ready !== 1'b0 || ifs.out_valid !== 1'b0 || ifs.div_q !== '0 || ifs.div_r !== '0 || dbg_s !== 2'd0) begin
      errors++;
      $display("FAIL reset_signed got ir=%b ov=%b q=%h r=%h st=%0d expected 0 0 0 0 0",
               ifs.in_ready, ifs.out_valid, ifs.div_q, ifs.div_r, dbg_s);
    end
    checks++;
    if (ifu.in_ready !== 1'b0 || ifu.out_valid !== 1'b0 || ifu.div_q !== '0 || ifu.div_r !== '0 || dbg_u !== 2'd0) begin
      errors++;
      $display("FAIL reset_unsigned got ir=%b ov=%b q=%h r=%h st=%0d expected 0 0 0 0 0",
               ifu.in_ready, ifu.out_valid, ifu.div_q, ifu.div_r, dbg_u);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ifs.in_ready !== 1'b1 || ifu.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_ready got %b%b expected 11", ifs.in_ready, ifu.in_ready);
    end
  endtask

  task automatic test_directed();
    do_op(1'b0, 32'd100, 32'd7);
    do_op(1'b1, 32'd100, 32'd7);
    do_op(1'b1, -32'sd7, 32'd2);
    do_op(1'b1, 32'd7, -32'sd2);
    do_op(1'b1, -32'sd100, -32'sd7);
    do_op(1'b0, 32'hFFFF_FFFF, 32'd1);
  endtask

  task automatic test_div_zero();
    do_op(1'b0, 32'd5, 32'd0);
    do_op(1'b1, 32'd5, 32'd0);
    do_op(1'b1, -32'sd5, 32'd0);
    do_op(1'b0, -32'sd5, 32'd0);
  endtask

  task automatic test_overflow();
    do_op(1'b1, MIN, 32'hFFFF_FFFF);
    do_op(1'b0, MIN, 32'hFFFF_FFFF);
    do_op(1'b1, MIN, MIN);
    do_op(1'b1, 32'd3, MIN);
  endtask

  task automatic test_hold();
    int edges;
    logic [2*W-1:0] e;
    start_op(1'b1, -32'sd1234567, 32'd89);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tb_a = $urandom;
      tb_b = $urandom_range(1, 50);
      tb_valid = 1'b1;
      checks++;
      if (obs_ir !== 1'b0) begin
        errors++;
        $display("FAIL busy_ready got %b expected 0", obs_ir);
      end
      @(posedge clk);
      #1;
      tb_valid = 1'b0;
    end
    wait_result(edges);
    e = exp_q[0];
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (obs_ov !== 1'b1 || obs_ir !== 1'b0 || {obs_q, obs_r} !== e) begin
        errors++;
        $display("FAIL hold got ov=%b ir=%b q=%h r=%h expected 1 0 %h %h",
                 obs_ov, obs_ir, obs_q, obs_r, e[2*W-1:W], e[W-1:0]);
      end
    end
    collect(edges + 5 - 10 + 10);
  endtask

  task automatic test_reset_mid();
    int spurious = 0;
    do_op(1'b1, 32'd999, 32'd10);
    start_op(1'b1, 32'd12345, 32'd6);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    void'(exp_q.pop_back());
    checks++;
    if (obs_ov !== 1'b0 || obs_q !== '0 || obs_r !== '0 || obs_ir !== 1'b0 || obs_st !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid got ov=%b q=%h r=%h ir=%b st=%0d expected 0 0 0 0 0",
               obs_ov, obs_q, obs_r, obs_ir, obs_st);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (obs_ov !== 1'b0) spurious++;
    end
    checks++;
    if (spurious != 0) begin
      errors++;
      $display("FAIL abandoned_result got %0d valid cycles expected 0", spurious);
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 9))
      0: return '0;
      1: return MIN;
      2: return '1;
      3: return 32'd1;
      4: return 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    for (int i = 0; i < 300; i++) do_op(1'($urandom_range(0, 1)), pick(), pick());
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) do_op(1'b0, $urandom, 32'($urandom_range(1, 1000)));
  endtask

  initial begin
    test_reset();
    test_directed();
    test_div_zero();
    test_overflow();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
